bias_buffer_reader: RTL and testbench
=====================================

# bias_buffer_reader

Read-side companion to the bias buffer fill path. It is configured with a start address and a bias count, then reads every bias buffer bank in parallel at each address. It concatenates the banks into one X_PE-byte bias vector and streams the vectors to the PE array over a valid/ready handshake. A 2-entry output queue absorbs the 1-cycle RAM read latency, so back-pressure never loses data.

## Interface
- X_PE, 16, PEs per row; one bias byte per PE
- ADDR_LEN, 16, bias buffer address width
- DATA_LEN, 64, width of one bias buffer bank
- SINGLE_LEN, 24, width of bias_num
- BUFFER_NUM, 8*X_PE/DATA_LEN, bank count (2 at defaults)

- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- conf  in  1  1-cycle start pulse; sampled only while idle
- bias_num  in  SINGLE_LEN  number of addresses to read
- bb_st_addr  in  ADDR_LEN  first bias buffer address
- bb_rd_en  out  1  read strobe, same to all banks
- bb_rd_addr  out  ADDR_LEN  read address, same to all banks
- bb_rd_data  in  BUFFER_NUM*DATA_LEN  bank i data on [i*DATA_LEN +: DATA_LEN]; valid 1 cycle after bb_rd_en
- bias_out  out  8*X_PE  bias vector; bank i data on bits [i*DATA_LEN +: DATA_LEN]
- bias_valid  out  1  bias_out holds a vector
- bias_ready  in  1  consumer accepts the vector
- done  out  1  1-cycle pulse when the job finishes
- idle  out  1  high in IDLE with the queue empty

## Operation
- States:
  - IDLE: conf with bias_num != 0 latches bias_num and bb_st_addr, then goes to READ. conf with bias_num == 0 issues no reads and pulses done the next cycle.
  - READ: issues reads bb_st_addr, bb_st_addr+1, … until bias_num reads are issued, then goes to DRAIN.
  - DRAIN: waits until the queue is empty and no read is in flight, then pulses done and returns to IDLE.
- Addresses add modulo 2^ADDR_LEN, so the read sequence wraps from all-ones to 0.
- Queue:
  - 2 entries, each 8*X_PE bits; the head drives bias_out.
  - in_flight = bb_rd_en delayed 1 cycle; when set, bb_rd_data is pushed that cycle.
  - A pop is bias_valid & bias_ready.
- Issue rule: bb_rd_en=1 in READ only when occupancy + in_flight − pop < 2. This guarantees no overflow.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- bias_valid = (occupancy != 0).
- Once bias_valid is high, bias_out and bias_valid stay stable until the handshake completes.
- conf is ignored when not idle; the job in progress is unaffected.
- Vector k of a job holds bank[i][bb_st_addr+k] for all i. This matches the fill order (bank 0 filled first, bias_num words per bank).

## Timing
- All outputs reset to 0; state resets to IDLE; queue is emptied; idle resets to 1.
- Reset is asynchronous; asserting it mid-job abandons the job with no done pulse.
- With bias_ready held high:
  - conf in cycle 0.
  - bb_rd_en and address st in cycle 1.
  - Data pushed in cycle 2.
  - bias_valid in cycle 3.
  - Throughput is 1 vector per cycle.
- done pulses the cycle after the final handshake; idle rises in that same cycle.
- With bias_ready low: at most 2 reads are issued beyond the last pop, then bb_rd_en holds at 0. Reads resume the cycle a pop frees a slot.
- bb_rd_addr holds its last value when bb_rd_en=0.

## Configuration
- BIAS_RD_GATE_EN:
  - Defined: bias_out is forced to 0 whenever bias_valid=0. This reduces toggling into the PE array.
  - Undefined: bias_out shows the raw head register, so the last vector stays visible after the queue drains.
  - Handshake timing is identical in both builds.

## Test plan
- Basic job: bias_num=3, bb_st_addr=0x0010, bias_ready=1, bank data = address pattern.
  - bb_rd_en in cycles 1–3 at addresses 0x10, 0x11, 0x12.
  - bias_valid in cycles 3–5 with matching vectors.
  - done in cycle 6.
- Back-pressure: bias_num=8 with bias_ready low for cycles 4–10.
  - No bb_rd_en while the queue plus in-flight count is 2.
  - All 8 vectors are delivered in order with none dropped or duplicated.
  - bias_out stays stable while stalled.
- Wrap: bb_st_addr=0xFFFE, bias_num=4 -> addresses FFFE, FFFF, 0000, 0001 in order.
- Zero count and busy conf:
  - bias_num=0 -> no bb_rd_en; done pulses the next cycle; idle stays high.
  - conf mid-job -> ignored; the original job completes unchanged.
- Reset mid-job: assert rst_n low during cycle 4 of an 8-entry job.
  - All outputs go to 0 immediately, with no done pulse.
  - A new conf afterwards runs normally.
- Macro: run the basic job with and without BIAS_RD_GATE_EN.
  - With it defined: bias_out is 0 after the drain.
  - Without it: bias_out holds the last vector (0x12 pattern) after the drain.

Source files
------------

// File: rtl/bias_buffer_reader.sv
// Bias buffer read side: streams bias_num bank-parallel words from bb_st_addr to the PE array.
// Optional build macro BIAS_RD_GATE_EN zeroes bias_out whenever no vector is valid.
module bias_buffer_reader #(
    parameter int X_PE       = 16,
    parameter int ADDR_LEN   = 16,
    parameter int DATA_LEN   = 64,
    parameter int SINGLE_LEN = 24
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   conf,
    input  logic [SINGLE_LEN-1:0]                  bias_num,
    input  logic [ADDR_LEN-1:0]                    bb_st_addr,
    output logic                                   bb_rd_en,
    output logic [ADDR_LEN-1:0]                    bb_rd_addr,
    input  logic [(8*X_PE/DATA_LEN)*DATA_LEN-1:0]  bb_rd_data,
    output logic [8*X_PE-1:0]                      bias_out,
    output logic                                   bias_valid,
    input  logic                                   bias_ready,
    output logic                                   done,
    output logic                                   idle,
    output logic [1:0]                             dbg_state
);

    localparam int BUFFER_NUM = 8*X_PE/DATA_LEN;
    localparam int VEC_W      = 8*X_PE;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Handshake: a vector transfers in any cycle where bias_valid and bias_ready are both high;
    // once bias_valid rises, bias_out and bias_valid hold until that transfer happens.

    logic [1:0]            state_q, state_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [ADDR_LEN-1:0]   last_addr_q, last_addr_d;
    logic [SINGLE_LEN-1:0] rem_q, rem_d;
    logic                  done_q, done_d;
    logic                  in_flight_q;
    logic [VEC_W-1:0]      q0_q, q0_d, q1_q, q1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pop, push, room, rd_en;

    assign bias_valid = (occ_q != 2'd0);
    assign pop        = bias_valid & bias_ready;
    assign push       = in_flight_q;
    // Count the read whose data lands next cycle so two slots are never oversubscribed.
    assign room       = ({1'b0, occ_q} + {2'b00, in_flight_q}) < (3'd2 + {2'b00, pop});
    assign rd_en      = (state_q == S_READ) && room;

    assign bb_rd_en   = rd_en;
    assign bb_rd_addr = rd_en ? addr_q : last_addr_q;
    assign done       = done_q;
    assign idle       = (state_q == S_IDLE) && (occ_q == 2'd0);
    assign dbg_state  = state_q;

`ifdef BIAS_RD_GATE_EN
    assign bias_out = bias_valid ? q0_q : '0;
`else
    assign bias_out = q0_q;
`endif

    // The head only moves on a pop from a full queue, so it keeps the last vector once drained.
    always_comb begin
        q0_d  = q0_q;
        q1_d  = q1_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) q0_d = bb_rd_data;
                else               q1_d = bb_rd_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) q0_d = q1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    q0_d = q1_q;
                    q1_d = bb_rd_data;
                end else begin
                    q0_d = bb_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (conf) begin
                    if (bias_num != '0) begin
                        state_d = S_READ;
                        addr_d  = bb_st_addr;
                        rem_d   = bias_num;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rd_en) begin
                    addr_d      = addr_q + ADDR_LEN'(1);
                    last_addr_d = addr_q;
                    rem_d       = rem_q - SINGLE_LEN'(1);
                    if (rem_q == SINGLE_LEN'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // No reads issue here, so an empty queue next cycle means the job is complete.
                if (occ_d == 2'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            rem_q       <= '0;
            done_q      <= 1'b0;
            in_flight_q <= 1'b0;
            q0_q        <= '0;
            q1_q        <= '0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
            in_flight_q <= rd_en;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            occ_q       <= occ_d;
        end
    end

    if (BUFFER_NUM * DATA_LEN != VEC_W) begin : g_bad_geometry
        $error("bank geometry must tile the bias vector exactly");
    end

endmodule

// File: tb/tb_bias_buffer_reader.sv
// Directed bench for bias_buffer_reader: hand-timed basic job plus scoreboarded jobs.
module tb_bias_buffer_reader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         conf = 1'b0;
    logic [23:0]  bias_num = '0;
    logic [15:0]  bb_st_addr = '0;
    logic         bb_rd_en;
    logic [15:0]  bb_rd_addr;
    logic [127:0] bb_rd_data = '0;
    logic [127:0] bias_out;
    logic         bias_valid;
    logic         bias_ready = 1'b0;
    logic         done;
    logic         idle;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;

    bias_buffer_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conf       (conf),
        .bias_num   (bias_num),
        .bb_st_addr (bb_st_addr),
        .bb_rd_en   (bb_rd_en),
        .bb_rd_addr (bb_rd_addr),
        .bb_rd_data (bb_rd_data),
        .bias_out   (bias_out),
        .bias_valid (bias_valid),
        .bias_ready (bias_ready),
        .done       (done),
        .idle       (idle),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Bank 1 in the upper 64 bits, bank 0 in the lower; each word encodes its address.
    function automatic logic [127:0] pat(input logic [15:0] a);
        return {16'hBA01, 16'h0000, a, ~a, 16'hBA00, 16'h0000, ~a, a};
    endfunction

    // Bias bank RAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (bb_rd_en) bb_rd_data <= pat(bb_rd_addr);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one job with a scoreboard; bias_ready is low over [stall_lo, stall_hi];
    // a stray conf is pulsed in cycle busy_at.
    task automatic run_job(input logic [15:0] st, input logic [23:0] n,
                           input int stall_lo, input int stall_hi, input int busy_at);
        logic [127:0] exp_q[$];
        logic [127:0] held;
        logic [15:0]  a;
        int issued = 0;
        int pops = 0;
        bit seen_done = 1'b0;
        bit stalled = 1'b0;
        conf = 1'b1;
        bias_num = n;
        bb_st_addr = st;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            if (c > 0) begin
                conf = (c == busy_at);
                bias_num = 24'd5;
                bb_st_addr = 16'h0BAD;
            end
            bias_ready = !(c >= stall_lo && c <= stall_hi);
            #1;
            if (stalled) begin
                chk("stall_valid", bias_valid, 1'b1);
                chk("stall_hold", bias_out, held);
            end
            if (bb_rd_en) begin
                a = st + 16'(issued);
                chk("rd_addr", bb_rd_addr, a);
                exp_q.push_back(pat(a));
                issued++;
            end
            if (bias_valid && bias_ready) begin
                if (exp_q.size() == 0) chk("spurious_vec", 1'b1, 1'b0);
                else chk("vec", bias_out, exp_q.pop_front());
                pops++;
            end
            chk("outstanding_le2", (issued - pops) <= 2, 1'b1);
            stalled = bias_valid && !bias_ready;
            held = bias_out;
            if (done) begin
                seen_done = 1'b1;
                chk("done_after_all_pops", pops, n);
                chk("idle_with_done", idle, 1'b1);
            end
            next_cycle();
        end
        conf = 1'b0;
        bias_ready = 1'b1;
        chk("job_done_seen", seen_done, 1'b1);
        chk("reads_issued", issued, n);
        chk("vectors_popped", pops, n);
        chk("done_single_pulse", done, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rd_en", bb_rd_en, 1'b0);
        chk("rst_rd_addr", bb_rd_addr, 16'h0);
        chk("rst_valid", bias_valid, 1'b0);
        chk("rst_bias_out", bias_out, 128'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_idle", idle, 1'b1);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Basic job, hand-timed: conf in cycle 0
        conf = 1'b1; bias_num = 24'd3; bb_st_addr = 16'h0010; bias_ready = 1'b1;
        #1;
        chk("b0_idle", idle, 1'b1);
        chk("b0_rd_en", bb_rd_en, 1'b0);
        next_cycle(); conf = 1'b0; #1;
        chk("b1_rd_en", bb_rd_en, 1'b1);
        chk("b1_addr", bb_rd_addr, 16'h0010);
        chk("b1_valid", bias_valid, 1'b0);
        chk("b1_idle", idle, 1'b0);
        next_cycle(); #1;
        chk("b2_rd_en", bb_rd_en, 1'b1);
        chk("b2_addr", bb_rd_addr, 16'h0011);
        chk("b2_valid", bias_valid, 1'b0);
        next_cycle(); #1;
        chk("b3_rd_en", bb_rd_en, 1'b1);
        chk("b3_addr", bb_rd_addr, 16'h0012);
        chk("b3_valid", bias_valid, 1'b1);
        chk("b3_vec", bias_out, pat(16'h0010));
        next_cycle(); #1;
        chk("b4_rd_en", bb_rd_en, 1'b0);
        chk("b4_addr_hold", bb_rd_addr, 16'h0012);
        chk("b4_vec", bias_out, pat(16'h0011));
        next_cycle(); #1;
        chk("b5_valid", bias_valid, 1'b1);
        chk("b5_vec", bias_out, pat(16'h0012));
        chk("b5_done", done, 1'b0);
        next_cycle(); #1;
        chk("b6_done", done, 1'b1);
        chk("b6_idle", idle, 1'b1);
        chk("b6_valid", bias_valid, 1'b0);
`ifdef BIAS_RD_GATE_EN
        chk("b6_out_gated", bias_out, 128'h0);
`else
        chk("b6_out_held", bias_out, pat(16'h0012));
`endif
        next_cycle(); #1;
        chk("b7_done", done, 1'b0);
        chk("b7_addr_hold", bb_rd_addr, 16'h0012);

        // Back-pressure: ready low in cycles 4..10 of an 8-entry job
        run_job(16'h0020, 24'd8, 4, 10, -1);
        // Address wrap
        run_job(16'hFFFE, 24'd4, -1, -1, -1);
        // conf while busy is ignored
        run_job(16'h0040, 24'd4, 6, 7, 2);

        // Zero count
        conf = 1'b1; bias_num = 24'd0; bb_st_addr = 16'h0300;
        #1;
        chk("z0_rd_en", bb_rd_en, 1'b0);
        next_cycle(); conf = 1'b0; #1;
        chk("z1_done", done, 1'b1);
        chk("z1_rd_en", bb_rd_en, 1'b0);
        chk("z1_idle", idle, 1'b1);
        next_cycle(); #1;
        chk("z2_done", done, 1'b0);
        chk("z2_rd_en", bb_rd_en, 1'b0);

        // Reset in cycle 4 of an 8-entry job
        conf = 1'b1; bias_num = 24'd8; bb_st_addr = 16'h0100; bias_ready = 1'b1;
        next_cycle(); conf = 1'b0;
        next_cycle(); next_cycle(); next_cycle();
        #1;
        chk("r4_busy_valid", bias_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("r_rd_en", bb_rd_en, 1'b0);
        chk("r_rd_addr", bb_rd_addr, 16'h0);
        chk("r_valid", bias_valid, 1'b0);
        chk("r_bias_out", bias_out, 128'h0);
        chk("r_done", done, 1'b0);
        next_cycle();
        chk("r_done_held", done, 1'b0);
        rst_n = 1'b1;
        next_cycle();
        chk("r_after_done", done, 1'b0);
        run_job(16'h0200, 24'd2, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
